// File: rtl/ram_2p_cfg_pkg.sv
// ram_2p_cfg_pkg: shared types and helpers for the dual-port configurable RAM.
//   resp_t       - one response beat (valid, err, rdata), rdata sized for the
//                  widest legal word (128 bits); narrower RAMs use the low bits.
//   byte_count   - bytes per word for a given data width.
//   index_width  - word-index width, at least 1 bit.
//   calc_parity  - even-parity bit for one byte.
package ram_2p_cfg_pkg;

  localparam int unsigned MaxWidth = 128;

  typedef struct packed {
    logic                valid;
    logic                err;
    logic [MaxWidth-1:0] rdata;
  } resp_t;

  function automatic int unsigned byte_count(input int unsigned width);
    return width / 8;
  endfunction

  function automatic int unsigned index_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic calc_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_2p_cfg_port.sv
// ram_2p_cfg_port: per-port front end of ram_2p_cfg.
//   Decodes the byte address into a word index, flags out-of-range requests,
//   builds the response beat and delays it by ReadLatency (1 or 2) cycles,
//   and counts accepted requests (wrapping 32-bit counter).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i, we_i        request strobe and write enable
//   addr_i             byte address
//   rd_word_i, perr_i  array word and parity error seen by this port
//   idx_o, ok_o        decoded word index and in-range flag
//   rvalid_o, rdata_o, err_o  delayed response
//   cnt_o              accepted request count
module ram_2p_cfg_port
  import ram_2p_cfg_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 128,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [31:0]                    addr_i,
  input  logic [Width-1:0]               rd_word_i,
  input  logic                           perr_i,
  output logic [index_width(Depth)-1:0]  idx_o,
  output logic                           ok_o,
  output logic                           rvalid_o,
  output logic [Width-1:0]               rdata_o,
  output logic                           err_o,
  output logic [31:0]                    cnt_o
);

  localparam int unsigned ByteOff = $clog2(byte_count(Width));
  localparam int unsigned Aw      = index_width(Depth);
  localparam logic [Aw:0] DepthL  = (Aw+1)'(Depth);

  logic [31:0] word_addr;
  resp_t       rsp_d, rsp_q, out_rsp;

  // Byte-offset bits are dropped here and never contribute to the error.
  assign word_addr = addr_i >> ByteOff;
  assign idx_o     = word_addr[Aw-1:0];
  assign ok_o      = ((word_addr >> Aw) == 32'd0) && ({1'b0, idx_o} < DepthL);

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = req_i;
    if (req_i) begin
      if (!ok_o) begin
        rsp_d.err = 1'b1;
      end else if (!we_i) begin
        rsp_d.err   = perr_i;
        rsp_d.rdata = MaxWidth'(rd_word_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rsp_q <= '0;
    else         rsp_q <= rsp_d;
  end

  if (ReadLatency == 2) begin : g_lat2
    resp_t rsp2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rsp2_q <= '0;
      else         rsp2_q <= rsp_q;
    end
    assign out_rsp = rsp2_q;
  end else begin : g_lat1
    assign out_rsp = rsp_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_o <= '0;
    else if (req_i) cnt_o <= cnt_o + 32'd1;
  end

  assign rvalid_o = out_rsp.valid;
  assign err_o    = out_rsp.err;
  assign rdata_o  = Width'(out_rsp.rdata);

endmodule

// File: rtl/ram_2p_cfg.sv
// ram_2p_cfg: parametrised dual-port synchronous RAM, single clock.
//   Width (8..128, multiple of 8), Depth (any), ReadLatency (1|2),
//   WriteFirst (0 read-first / 1 write-first on cross-port collision).
//   MemInitFile is kept for drop-in compatibility; contents are not preloaded
//   by this model and start undefined.
//   Optional macro RAM_2P_CFG_PARITY_EN adds one even-parity bit per byte and
//   the parity_flip_i input (inverts parity stored by the next write).
// Ports (x = a|b):
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   x_req_i, x_we_i, x_be_i          request, write enable, byte enables
//   x_addr_i, x_wdata_i              byte address, write data
//   x_rvalid_o, x_rdata_o, x_err_o   response (rdata/err zero when not valid)
//   a_cnt_o, b_cnt_o                 accepted requests per port, wrapping
module ram_2p_cfg
  import ram_2p_cfg_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 128,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned WriteFirst  = 0,
  parameter string       MemInitFile = ""
) (
  input  logic               clk_i,
  input  logic               rst_ni,
`ifdef RAM_2P_CFG_PARITY_EN
  input  logic [Width/8-1:0] parity_flip_i,
`endif
  input  logic               a_req_i,
  input  logic               a_we_i,
  input  logic [Width/8-1:0] a_be_i,
  input  logic [31:0]        a_addr_i,
  input  logic [Width-1:0]   a_wdata_i,
  output logic               a_rvalid_o,
  output logic [Width-1:0]   a_rdata_o,
  output logic               a_err_o,
  input  logic               b_req_i,
  input  logic               b_we_i,
  input  logic [Width/8-1:0] b_be_i,
  input  logic [31:0]        b_addr_i,
  input  logic [Width-1:0]   b_wdata_i,
  output logic               b_rvalid_o,
  output logic [Width-1:0]   b_rdata_o,
  output logic               b_err_o,
  output logic [31:0]        a_cnt_o,
  output logic [31:0]        b_cnt_o
);

  localparam int unsigned Nb = byte_count(Width);
  localparam int unsigned Aw = index_width(Depth);

  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0]    a_idx, b_idx;
  logic             a_ok, b_ok, a_wr, b_wr, same_idx;
  logic [Width-1:0] a_view, b_view;
  logic             a_perr, b_perr;

`ifdef RAM_2P_CFG_PARITY_EN
  logic [Nb-1:0] par_mem [Depth];
  logic [Nb-1:0] a_pview, b_pview, a_pnew, b_pnew;
`endif

  assign a_wr     = a_req_i & a_we_i & a_ok;
  assign b_wr     = b_req_i & b_we_i & b_ok;
  assign same_idx = (a_idx == b_idx);

  // B is applied first so that A's byte wins where both ports write it.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Nb; i++) begin
      if (b_wr && b_be_i[i]) begin
        mem[b_idx][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
`ifdef RAM_2P_CFG_PARITY_EN
        par_mem[b_idx][i] <= b_pnew[i];
`endif
      end
      if (a_wr && a_be_i[i]) begin
        mem[a_idx][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
`ifdef RAM_2P_CFG_PARITY_EN
        par_mem[a_idx][i] <= a_pnew[i];
`endif
      end
    end
  end

  // Word seen by each reader: the stored word, or under write-first the word
  // with the other port's enabled bytes already merged in.
  always_comb begin
    a_view = a_ok ? mem[a_idx] : '0;
    b_view = b_ok ? mem[b_idx] : '0;
`ifdef RAM_2P_CFG_PARITY_EN
    a_pview = a_ok ? par_mem[a_idx] : '0;
    b_pview = b_ok ? par_mem[b_idx] : '0;
    for (int unsigned i = 0; i < Nb; i++) begin
      a_pnew[i] = calc_parity(a_wdata_i[i*8 +: 8]) ^ parity_flip_i[i];
      b_pnew[i] = calc_parity(b_wdata_i[i*8 +: 8]) ^ parity_flip_i[i];
    end
`endif
    if (WriteFirst != 0 && same_idx) begin
      for (int unsigned i = 0; i < Nb; i++) begin
        if (b_wr && b_be_i[i]) begin
          a_view[i*8 +: 8] = b_wdata_i[i*8 +: 8];
`ifdef RAM_2P_CFG_PARITY_EN
          a_pview[i] = b_pnew[i];
`endif
        end
        if (a_wr && a_be_i[i]) begin
          b_view[i*8 +: 8] = a_wdata_i[i*8 +: 8];
`ifdef RAM_2P_CFG_PARITY_EN
          b_pview[i] = a_pnew[i];
`endif
        end
      end
    end
`ifdef RAM_2P_CFG_PARITY_EN
    a_perr = 1'b0;
    b_perr = 1'b0;
    for (int unsigned i = 0; i < Nb; i++) begin
      a_perr = a_perr | (a_pview[i] ^ calc_parity(a_view[i*8 +: 8]));
      b_perr = b_perr | (b_pview[i] ^ calc_parity(b_view[i*8 +: 8]));
    end
`else
    a_perr = 1'b0;
    b_perr = 1'b0;
`endif
  end

  ram_2p_cfg_port #(
    .Width      (Width),
    .Depth      (Depth),
    .ReadLatency(ReadLatency)
  ) u_port_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (a_req_i),
    .we_i     (a_we_i),
    .addr_i   (a_addr_i),
    .rd_word_i(a_view),
    .perr_i   (a_perr),
    .idx_o    (a_idx),
    .ok_o     (a_ok),
    .rvalid_o (a_rvalid_o),
    .rdata_o  (a_rdata_o),
    .err_o    (a_err_o),
    .cnt_o    (a_cnt_o)
  );

  ram_2p_cfg_port #(
    .Width      (Width),
    .Depth      (Depth),
    .ReadLatency(ReadLatency)
  ) u_port_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (b_req_i),
    .we_i     (b_we_i),
    .addr_i   (b_addr_i),
    .rd_word_i(b_view),
    .perr_i   (b_perr),
    .idx_o    (b_idx),
    .ok_o     (b_ok),
    .rvalid_o (b_rvalid_o),
    .rdata_o  (b_rdata_o),
    .err_o    (b_err_o),
    .cnt_o    (b_cnt_o)
  );

endmodule

// File: tb/tb_ram_2p_cfg.sv
// tb_ram_2p_cfg: checks two ram_2p_cfg instances against a behavioural model.
//   dut0: Width=32, Depth=100, ReadLatency=1, read-first
//   dut1: Width=64, Depth=100, ReadLatency=2, write-first
module tb_ram_2p_cfg;

  localparam int unsigned Depth = 100;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [63:0] d;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // Stimulus indexed [dut][port], port 0 = A, 1 = B.
  logic        req  [2][2];
  logic        we   [2][2];
  logic [7:0]  be   [2][2];
  logic [31:0] addr [2][2];
  logic [63:0] wd   [2][2];

  logic        d0a_rv, d0a_er, d0b_rv, d0b_er, d1a_rv, d1a_er, d1b_rv, d1b_er;
  logic [31:0] d0a_rd, d0b_rd;
  logic [63:0] d1a_rd, d1b_rd;
  logic [31:0] d0a_cnt, d0b_cnt, d1a_cnt, d1b_cnt;

  exp_t        pipe [2][2][2];
  logic [63:0] mdl  [2][Depth];
  logic [31:0] mcnt [2][2];
  int unsigned total = 0;
  int unsigned bad   = 0;

  ram_2p_cfg #(.Width(32), .Depth(Depth), .ReadLatency(1), .WriteFirst(0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef RAM_2P_CFG_PARITY_EN
    .parity_flip_i(4'h0),
`endif
    .a_req_i(req[0][0]), .a_we_i(we[0][0]), .a_be_i(be[0][0][3:0]),
    .a_addr_i(addr[0][0]), .a_wdata_i(wd[0][0][31:0]),
    .a_rvalid_o(d0a_rv), .a_rdata_o(d0a_rd), .a_err_o(d0a_er),
    .b_req_i(req[0][1]), .b_we_i(we[0][1]), .b_be_i(be[0][1][3:0]),
    .b_addr_i(addr[0][1]), .b_wdata_i(wd[0][1][31:0]),
    .b_rvalid_o(d0b_rv), .b_rdata_o(d0b_rd), .b_err_o(d0b_er),
    .a_cnt_o(d0a_cnt), .b_cnt_o(d0b_cnt)
  );

  ram_2p_cfg #(.Width(64), .Depth(Depth), .ReadLatency(2), .WriteFirst(1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef RAM_2P_CFG_PARITY_EN
    .parity_flip_i(8'h00),
`endif
    .a_req_i(req[1][0]), .a_we_i(we[1][0]), .a_be_i(be[1][0]),
    .a_addr_i(addr[1][0]), .a_wdata_i(wd[1][0]),
    .a_rvalid_o(d1a_rv), .a_rdata_o(d1a_rd), .a_err_o(d1a_er),
    .b_req_i(req[1][1]), .b_we_i(we[1][1]), .b_be_i(be[1][1]),
    .b_addr_i(addr[1][1]), .b_wdata_i(wd[1][1]),
    .b_rvalid_o(d1b_rv), .b_rdata_o(d1b_rd), .b_err_o(d1b_er),
    .a_cnt_o(d1a_cnt), .b_cnt_o(d1b_cnt)
  );

  function automatic int unsigned nb(input int d);   return (d == 1) ? 8 : 4; endfunction
  function automatic int unsigned boff(input int d); return (d == 1) ? 3 : 2; endfunction
  function automatic int unsigned lat(input int d);  return (d == 1) ? 2 : 1; endfunction
  function automatic bit          wf(input int d);   return (d == 1); endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int d, input int p, output logic v, output logic e,
                         output logic [63:0] rd, output logic [31:0] c);
    case ({d[0], p[0]})
      2'b00:   begin v = d0a_rv; e = d0a_er; rd = {32'h0, d0a_rd}; c = d0a_cnt; end
      2'b01:   begin v = d0b_rv; e = d0b_er; rd = {32'h0, d0b_rd}; c = d0b_cnt; end
      2'b10:   begin v = d1a_rv; e = d1a_er; rd = d1a_rd;          c = d1a_cnt; end
      default: begin v = d1b_rv; e = d1b_er; rd = d1b_rd;          c = d1b_cnt; end
    endcase
  endtask

  // One clock of the reference model for dut d: word-level arithmetic on the
  // current inputs, responses queued into a latency delay line.
  task automatic model_cycle(input int d);
    logic [31:0] w  [2];
    logic        ok [2];
    logic        wr [2];
    exp_t        r  [2];
    logic [63:0] v;
    int          q;
    for (int p = 0; p < 2; p++) begin
      w[p]  = addr[d][p] >> boff(d);
      ok[p] = (w[p] < Depth);
      wr[p] = req[d][p] && we[d][p] && ok[p];
    end
    for (int p = 0; p < 2; p++) begin
      q    = 1 - p;
      r[p] = '0;
      if (req[d][p]) begin
        r[p].v = 1'b1;
        if (!ok[p]) begin
          r[p].e = 1'b1;
        end else if (!we[d][p]) begin
          v = mdl[d][w[p]];
          if (wf(d) && wr[q] && w[q] == w[p])
            for (int i = 0; i < int'(nb(d)); i++)
              if (be[d][q][i]) v[i*8 +: 8] = wd[d][q][i*8 +: 8];
          r[p].d = v;
        end
      end
    end
    // B first, then A, so A's data survives on shared bytes.
    for (int p = 1; p >= 0; p--)
      if (wr[p])
        for (int i = 0; i < int'(nb(d)); i++)
          if (be[d][p][i]) mdl[d][w[p]][i*8 +: 8] = wd[d][p][i*8 +: 8];
    for (int p = 0; p < 2; p++) begin
      if (req[d][p]) mcnt[d][p] = mcnt[d][p] + 32'd1;
      pipe[d][p][1] = pipe[d][p][0];
      pipe[d][p][0] = r[p];
    end
  endtask

  task automatic check_all();
    logic v, e;
    logic [63:0] rd;
    logic [31:0] c;
    exp_t x;
    string tag;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        get_out(d, p, v, e, rd, c);
        x   = pipe[d][p][lat(d)-1];
        tag = $sformatf("dut%0d.%s", d, (p == 0) ? "a" : "b");
        chk({tag, ".rvalid"}, {63'h0, v}, {63'h0, x.v});
        chk({tag, ".err"},    {63'h0, e}, {63'h0, x.e});
        chk({tag, ".rdata"},  rd, x.d);
        chk({tag, ".cnt"},    {32'h0, c}, {32'h0, mcnt[d][p]});
      end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) model_cycle(d);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; be[d][p] = 8'h00;
        addr[d][p] = 32'h0; wd[d][p] = 64'h0;
      end
  endtask

  task automatic set(input int d, input int p, input logic r, input logic w,
                     input logic [7:0] b, input logic [31:0] a, input logic [63:0] x);
    req[d][p] = r; we[d][p] = w; be[d][p] = b; addr[d][p] = a; wd[d][p] = x;
  endtask

  task automatic clear_resp();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        pipe[d][p][0] = '0; pipe[d][p][1] = '0; mcnt[d][p] = '0;
      end
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int unsigned k;
    logic [31:0] w;
    k = $urandom_range(0, 15);
    if (k == 0) return $urandom;
    w = (k < 3) ? 32'($urandom_range(96, 140)) : 32'($urandom_range(0, 7));
    return (w << boff(d)) | 32'($urandom_range(0, nb(d) - 1));
  endfunction

  initial begin
    logic v, e;
    logic [63:0] rd;
    logic [31:0] c;
    logic [63:0] vals [4];

    idle();
    clear_resp();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < int'(Depth); w++) mdl[d][w] = '0;
    repeat (2) @(negedge clk_i);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        get_out(d, p, v, e, rd, c);
        chk("reset.rvalid", {63'h0, v}, 64'h0);
        chk("reset.err",    {63'h0, e}, 64'h0);
        chk("reset.rdata",  rd, 64'h0);
        chk("reset.cnt",    {32'h0, c}, 64'h0);
      end
    rst_ni = 1'b1;

    // Give every word a defined value.
    for (int w = 0; w < int'(Depth) / 2; w++) begin
      for (int d = 0; d < 2; d++) begin
        set(d, 0, 1'b1, 1'b1, 8'hFF, 32'(2*w)   << boff(d), {$urandom, $urandom});
        set(d, 1, 1'b1, 1'b1, 8'hFF, 32'(2*w+1) << boff(d), {$urandom, $urandom});
      end
      step();
    end
    idle(); step();

    // dut0 directed: write/read, byte merge, collisions, range.
    idle(); set(0, 0, 1'b1, 1'b1, 8'h0F, 32'h10, 64'hDEADBEEF); step();
    idle(); set(0, 0, 1'b1, 1'b0, 8'h00, 32'h10, 64'h0); step();
    get_out(0, 0, v, e, rd, c);
    chk("wr_rd.rvalid", {63'h0, v}, 64'h1);
    chk("wr_rd.rdata", rd, 64'hDEADBEEF);
    chk("wr_rd.err", {63'h0, e}, 64'h0);

    idle(); set(0, 0, 1'b1, 1'b1, 8'h0F, 32'h20, 64'h11223344); step();
    idle(); set(0, 0, 1'b1, 1'b1, 8'h02, 32'h20, 64'hAABBCCDD); step();
    idle(); set(0, 0, 1'b1, 1'b0, 8'h00, 32'h20, 64'h0); step();
    get_out(0, 0, v, e, rd, c);
    chk("merge.rdata", rd, 64'h1122CC44);

    idle();
    set(0, 0, 1'b1, 1'b1, 8'h0F, 32'h14, 64'hAAAAAAAA);
    set(0, 1, 1'b1, 1'b1, 8'h0F, 32'h14, 64'h55555555);
    step();
    idle();
    set(0, 0, 1'b1, 1'b1, 8'h0F, 32'h14, 64'h1);
    set(0, 1, 1'b1, 1'b0, 8'h00, 32'h14, 64'h0);
    step();
    get_out(0, 1, v, e, rd, c);
    chk("coll_rf.rdata", rd, 64'hAAAAAAAA);
    idle(); set(0, 1, 1'b1, 1'b0, 8'h00, 32'h14, 64'h0); step();
    get_out(0, 1, v, e, rd, c);
    chk("coll_after.rdata", rd, 64'h1);

    idle(); set(0, 0, 1'b1, 1'b0, 8'h00, 32'h190, 64'h0); step();
    get_out(0, 0, v, e, rd, c);
    chk("oor.rvalid", {63'h0, v}, 64'h1);
    chk("oor.err", {63'h0, e}, 64'h1);
    chk("oor.rdata", rd, 64'h0);
    idle(); set(0, 0, 1'b1, 1'b0, 8'h00, 32'h18F, 64'h0); step();
    get_out(0, 0, v, e, rd, c);
    chk("last_idx.err", {63'h0, e}, 64'h0);
    chk("last_idx.rvalid", {63'h0, v}, 64'h1);

    // dut1 write-first collision at index 5.
    idle();
    set(1, 0, 1'b1, 1'b1, 8'hFF, 32'h28, 64'hAAAAAAAAAAAAAAAA);
    set(1, 1, 1'b1, 1'b1, 8'hFF, 32'h28, 64'h5555555555555555);
    step();
    idle();
    set(1, 0, 1'b1, 1'b1, 8'hFF, 32'h28, 64'h1);
    set(1, 1, 1'b1, 1'b0, 8'h00, 32'h28, 64'h0);
    step();
    idle(); step();
    get_out(1, 1, v, e, rd, c);
    chk("coll_wf.rdata", rd, 64'h1);

    // dut1: known data, read in flight, reset before it completes.
    for (int k = 0; k < 4; k++) begin
      vals[k] = 64'h0123456789ABCD00 + 64'(k);
      idle(); set(1, 0, 1'b1, 1'b1, 8'hFF, 32'(10 + k) << 3, vals[k]); step();
    end
    idle(); set(1, 1, 1'b1, 1'b0, 8'h00, 32'h50, 64'h0); step();
    idle();
    #2 rst_ni = 1'b0;
    clear_resp();
    @(negedge clk_i);
    check_all();
    rst_ni = 1'b1;
    repeat (3) step();

    for (int k = 0; k < 4; k++) begin
      idle(); set(1, 1, 1'b1, 1'b0, 8'h00, 32'(10 + k) << 3, 64'h0); step();
      get_out(1, 1, v, e, rd, c);
      if (k == 0) chk("lat2.gap", {63'h0, v}, 64'h0);
      else        chk("lat2.rdata", rd, vals[k-1]);
    end
    idle(); step();
    get_out(1, 1, v, e, rd, c);
    chk("lat2.last", rd, vals[3]);
    chk("lat2.cnt", {32'h0, c}, 64'd4);
    step();
    get_out(1, 1, v, e, rd, c);
    chk("lat2.done", {63'h0, v}, 64'h0);

    // Random traffic on all four ports.
    repeat (3000) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          set(d, p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              8'($urandom), rand_addr(d), {$urandom, $urandom});
      step();
    end
    idle(); repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
